ps2_key_receiver: RTL and testbench
===================================

PS2_KEY_RECEIVER -- requirements
Module: ps2_key_receiver

Interface
REQ-001 Parameter FILTER_LEN, default 4: number of consecutive identical synchronised samples needed before PS2_CLK or PS2_DATA changes filtered level.
REQ-002 Parameter TIMEOUT_CYCLES, default 50000: maximum CLK cycles allowed between filtered PS2_CLK falling edges inside a frame.
REQ-003 Parameter FIFO_DEPTH, default 8: event FIFO depth; power of two, minimum 2.
REQ-004 CLK  input  1  system clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 PS2_CLK  input  1  asynchronous PS/2 clock line from the device.
REQ-007 PS2_DATA  input  1  asynchronous PS/2 data line from the device.
REQ-008 rd_en  input  1  pops the FIFO head when rd_valid=1; ignored otherwise.
REQ-009 rd_valid  output  1  FIFO non-empty.
REQ-010 rd_data  output  10  FIFO head, first-word-fall-through: {extended, release, code[7:0]}.
REQ-011 fifo_count  output  clog2(FIFO_DEPTH)+1  current occupancy.
REQ-012 parity_err  output  1  one-cycle pulse on a parity failure.
REQ-013 frame_err  output  1  one-cycle pulse on a bad stop bit or timeout.
REQ-014 overflow  output  1  sticky; set when an event is dropped because the FIFO is full.

Function
REQ-015 The block SHALL pass PS2_CLK and PS2_DATA through two-flop synchronisers, then through FILTER_LEN glitch filters; the filtered levels SHALL reset to 1.
REQ-016 A filtered PS2_CLK 1->0 transition SHALL be a sample event; filtered PS2_DATA SHALL be sampled in that cycle.
REQ-017 The FSM SHALL have states IDLE, DATA, PARITY and STOP.
REQ-018 IDLE: on a sample event with data=0 (start bit), go to DATA with bit count 0; data=1 SHALL be ignored and the FSM stays in IDLE.
REQ-019 DATA: shift 8 bits, LSB first; after the 8th sample, go to PARITY.
REQ-020 PARITY: capture the bit; odd parity over the 8 data bits plus parity is required; then go to STOP.
REQ-021 STOP: the sampled stop bit SHALL be 1; go to IDLE.
REQ-022 If parity is bad and the stop bit is 1, parity_err SHALL pulse, the byte SHALL be discarded and the prefix flags cleared.
REQ-023 If the stop bit is 0, frame_err SHALL pulse (parity_err SHALL NOT pulse), the byte SHALL be discarded and the prefix flags cleared.
REQ-024 On a good byte: 0xE0 sets the extended flag; 0xF0 sets the release flag; neither is pushed.
REQ-025 On any other good byte, {extended, release, byte} SHALL be pushed and both flags cleared.
REQ-026 A timeout counter SHALL clear on every sample event and in IDLE; when it reaches TIMEOUT_CYCLES outside IDLE, frame_err SHALL pulse, the FSM SHALL return to IDLE, the partial byte SHALL be discarded and the flags cleared.
REQ-027 Prefix flags SHALL persist across frames until consumed or cleared by an error.
REQ-028 Push timing: the push register update SHALL occur in the stop-bit sample cycle N; rd_valid SHALL be 1 and rd_data valid from cycle N+1.
REQ-029 Pop: rd_en=1 with rd_valid=1 removes the head at the clock edge; the next entry, if any, SHALL be visible the following cycle.
REQ-030 Full without pop: the push SHALL be dropped, overflow SHALL be set, and FIFO contents SHALL be unchanged.
REQ-031 Full with simultaneous pop: both push and pop SHALL take effect; count is unchanged; overflow SHALL NOT be set.
REQ-032 Empty with rd_en=1: no effect; count SHALL NOT underflow.
REQ-033 Read and write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-034 While reset=1, the following SHALL hold at the next edge: FSM=IDLE; bit count, shift register, timeout counter and flags cleared; FIFO emptied (rd_valid=0, fifo_count=0, rd_data=0); parity_err=0, frame_err=0, overflow=0.
REQ-035 Reset asserted mid-frame SHALL abandon the frame without any error pulse or push.
REQ-036 Filtered line levels SHALL return to 1 on reset.

Verification
REQ-037 Frame 0x1C with parity 0 and stop 1 -> one entry 0x01C; rd_valid rises one cycle after the stop sample.
REQ-038 Byte sequence E0, F0, 75 -> single entry 0x375; a following 1C -> entry 0x01C (flags cleared).
REQ-039 Frame 0x1C with parity 1 -> parity_err one-cycle pulse; no push; fifo_count stays 0.
REQ-040 Four bits of a frame, then idle for TIMEOUT_CYCLES -> frame_err pulse; FSM in IDLE; next full frame 0x29 -> entry 0x029.
REQ-041 FIFO_DEPTH+1 frames with no reads -> fifo_count=FIFO_DEPTH, overflow=1, head is still the first byte; a push coincident with rd_en at full -> count unchanged, overflow not newly set.
REQ-042 PS2_CLK glitch of FILTER_LEN-1 cycles low while idle -> no sample event and no state change; reset asserted at bit 5 -> no push or error pulse, and all outputs at their reset values.

Source files
------------

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: synchronises and de-glitches the PS/2 lines, decodes
// 11-bit frames, folds E0/F0 prefixes into flags and queues key events in a FWFT FIFO.
module ps2_key_receiver #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                          CLK,
  input  logic                          reset,
  input  logic                          PS2_CLK,
  input  logic                          PS2_DATA,
  input  logic                          rd_en,
  output logic                          rd_valid,
  output logic [9:0]                    rd_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_t;

  // Frame is good when data bits plus parity bit hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

  logic           clk_meta_r, clk_sync_r, data_meta_r, data_sync_r;
  logic           clk_filt_r, data_filt_r, clk_prev_r;
  logic [FCW-1:0] clk_fcnt_r, data_fcnt_r;
  state_t         state_r, state_nxt_s;
  logic [2:0]     bit_cnt_r;
  logic [7:0]     shift_r;
  logic           par_r;
  logic [TCW-1:0] tmo_cnt_r;
  logic           ext_r, rel_r;
  logic           sample_s, timeout_s, par_ok_s;
  logic           push_s, perr_s, ferr_s, set_ext_s, set_rel_s;
  logic [9:0]     mem_r [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr_r, rd_ptr_r, rd_ptr_nxt_s;
  logic [CW-1:0]  count_nxt_s;
  logic [9:0]     wdata_s, head_nxt_s;
  logic           pop_s, full_s, push_ok_s, ovf_s;

  // Two-flop synchronisers for both PS/2 lines.
  always_ff @(posedge CLK) begin
    if (reset) begin
      clk_meta_r  <= 1'b1;
      clk_sync_r  <= 1'b1;
      data_meta_r <= 1'b1;
      data_sync_r <= 1'b1;
    end else begin
      clk_meta_r  <= PS2_CLK;
      clk_sync_r  <= clk_meta_r;
      data_meta_r <= PS2_DATA;
      data_sync_r <= data_meta_r;
    end
  end

  // Clock-line glitch filter: level follows only after FILTER_LEN differing samples.
  always_ff @(posedge CLK) begin
    if (reset) begin
      clk_filt_r <= 1'b1;
      clk_fcnt_r <= {FCW{1'b0}};
    end else if (clk_sync_r == clk_filt_r) begin
      clk_fcnt_r <= {FCW{1'b0}};
    end else if (clk_fcnt_r == FCW'(FILTER_LEN - 1)) begin
      clk_filt_r <= clk_sync_r;
      clk_fcnt_r <= {FCW{1'b0}};
    end else begin
      clk_fcnt_r <= clk_fcnt_r + FCW'(1);
    end
  end

  // Data-line glitch filter, same rule as the clock line.
  always_ff @(posedge CLK) begin
    if (reset) begin
      data_filt_r <= 1'b1;
      data_fcnt_r <= {FCW{1'b0}};
    end else if (data_sync_r == data_filt_r) begin
      data_fcnt_r <= {FCW{1'b0}};
    end else if (data_fcnt_r == FCW'(FILTER_LEN - 1)) begin
      data_filt_r <= data_sync_r;
      data_fcnt_r <= {FCW{1'b0}};
    end else begin
      data_fcnt_r <= data_fcnt_r + FCW'(1);
    end
  end

  // Previous filtered clock level for falling-edge detection.
  always_ff @(posedge CLK) begin
    if (reset) clk_prev_r <= 1'b1;
    else       clk_prev_r <= clk_filt_r;
  end

  assign sample_s  = clk_prev_r & ~clk_filt_r;
  assign timeout_s = (state_r != ST_IDLE) && !sample_s && (tmo_cnt_r == TCW'(TIMEOUT_CYCLES));
  assign par_ok_s  = odd_parity_ok(shift_r, par_r);

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_nxt_s;
  end

  // FSM next-state logic; a timeout abandons the frame from any non-idle state.
  always_comb begin
    state_nxt_s = state_r;
    if (timeout_s) begin
      state_nxt_s = ST_IDLE;
    end else if (sample_s) begin
      case (state_r)
        ST_IDLE:   state_nxt_s = data_filt_r ? ST_IDLE : ST_DATA;
        ST_DATA:   state_nxt_s = (bit_cnt_r == 3'd7) ? ST_PARITY : ST_DATA;
        ST_PARITY: state_nxt_s = ST_STOP;
        ST_STOP:   state_nxt_s = ST_IDLE;
        default:   state_nxt_s = ST_IDLE;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // FSM outputs: frame verdict decided in the stop-bit sample cycle.
  always_comb begin
    push_s    = 1'b0;
    perr_s    = 1'b0;
    ferr_s    = timeout_s;
    set_ext_s = 1'b0;
    set_rel_s = 1'b0;
    case (state_r)
      ST_STOP: begin
        if (sample_s) begin
          if (!data_filt_r)            ferr_s    = 1'b1;
          else if (!par_ok_s)          perr_s    = 1'b1;
          else if (shift_r == 8'hE0)   set_ext_s = 1'b1;
          else if (shift_r == 8'hF0)   set_rel_s = 1'b1;
          else                         push_s    = 1'b1;
        end else begin
          push_s = 1'b0;
        end
      end
      default: push_s = 1'b0;
    endcase
  end

  // Frame datapath: bit counter, LSB-first shifter, parity capture, timeout, prefix flags.
  always_ff @(posedge CLK) begin
    if (reset) begin
      bit_cnt_r  <= 3'd0;
      shift_r    <= 8'h00;
      par_r      <= 1'b0;
      tmo_cnt_r  <= {TCW{1'b0}};
      ext_r      <= 1'b0;
      rel_r      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: if (sample_s) begin
          bit_cnt_r <= 3'd0;
          shift_r   <= 8'h00;
        end
        ST_DATA: if (sample_s) begin
          shift_r   <= {data_filt_r, shift_r[7:1]};
          bit_cnt_r <= bit_cnt_r + 3'd1;
        end
        ST_PARITY: if (sample_s) par_r <= data_filt_r;
        default: par_r <= par_r;
      endcase
      if (state_r == ST_IDLE || sample_s || timeout_s) tmo_cnt_r <= {TCW{1'b0}};
      else                                             tmo_cnt_r <= tmo_cnt_r + TCW'(1);
      if (push_s || perr_s || ferr_s) begin
        ext_r <= 1'b0;
        rel_r <= 1'b0;
      end else begin
        if (set_ext_s) ext_r <= 1'b1;
        if (set_rel_s) rel_r <= 1'b1;
      end
      parity_err <= perr_s;
      frame_err  <= ferr_s;
    end
  end

  assign wdata_s      = {ext_r, rel_r, shift_r};
  assign pop_s        = rd_en & rd_valid;
  assign full_s       = (fifo_count == CW'(FIFO_DEPTH));
  assign push_ok_s    = push_s & (!full_s | pop_s);
  assign ovf_s        = push_s & full_s & !pop_s;
  assign rd_ptr_nxt_s = pop_s ? rd_ptr_r + PW'(1) : rd_ptr_r;
  assign count_nxt_s  = fifo_count + CW'(push_ok_s) - CW'(pop_s);

  // Next FIFO head; a word written this cycle that becomes the head bypasses the array.
  always_comb begin
    if (count_nxt_s == {CW{1'b0}})                         head_nxt_s = 10'h000;
    else if (push_ok_s && (rd_ptr_nxt_s == wr_ptr_r))      head_nxt_s = wdata_s;
    else                                                   head_nxt_s = mem_r[rd_ptr_nxt_s];
  end

  // FIFO storage array.
  always_ff @(posedge CLK) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= wdata_s;
  end

  // FIFO pointers, occupancy, registered head and sticky overflow.
  always_ff @(posedge CLK) begin
    if (reset) begin
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      fifo_count <= {CW{1'b0}};
      rd_valid   <= 1'b0;
      rd_data    <= 10'h000;
      overflow   <= 1'b0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      rd_ptr_r   <= rd_ptr_nxt_s;
      fifo_count <= count_nxt_s;
      rd_valid   <= (count_nxt_s != {CW{1'b0}});
      rd_data    <= head_nxt_s;
      if (ovf_s) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Scoreboard bench for ps2_key_receiver: drives PS/2 frames, queues expected
// FIFO entries from a small decode model and checks them as they are read out.
module tb_ps2_key_receiver;

  localparam int FL   = 4;
  localparam int TO   = 200;
  localparam int FD   = 4;
  localparam int HALF = 10;
  localparam int LAT  = 2 + FL;

  logic       CLK = 1'b0;
  logic       reset, PS2_CLK, PS2_DATA, rd_en;
  logic       rd_valid, parity_err, frame_err, overflow;
  logic [9:0] rd_data;
  logic [$clog2(FD):0] fifo_count;

  int n_checks = 0;
  int n_fail   = 0;
  int perr_cnt = 0;
  int ferr_cnt = 0;
  int p0, f0;

  logic [9:0] exp_q[$];
  logic       mdl_ext, mdl_rel;
  int         mdl_count;

  ps2_key_receiver #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .FIFO_DEPTH(FD)) dut (
    .CLK(CLK), .reset(reset), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA), .rd_en(rd_en),
    .rd_valid(rd_valid), .rd_data(rd_data), .fifo_count(fifo_count),
    .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  // Count error pulses, one per high cycle.
  always @(posedge CLK) begin
    if (parity_err) perr_cnt <= perr_cnt + 1;
    if (frame_err)  ferr_cnt <= ferr_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_bit(input logic b, input bit last, input bit pop, input bit chk_lat);
    PS2_DATA = b;
    tick(HALF);
    PS2_CLK = 1'b0;
    for (int k = 1; k <= HALF; k++) begin
      @(posedge CLK);
      #1;
      rd_en = 1'b0;
      if (last && pop && k == LAT) begin
        if (exp_q.size() > 0) begin
          check("pop_at_push_head", rd_data, exp_q[0]);
          void'(exp_q.pop_front());
          mdl_count--;
        end
        rd_en = 1'b1;
      end
      if (last && chk_lat && k == LAT)     check("lat_before_push", rd_valid, 1'b0);
      if (last && chk_lat && k == LAT + 1) check("lat_after_push", rd_valid, 1'b1);
    end
    rd_en   = 1'b0;
    PS2_CLK = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input bit pop, input bit chk_lat);
    logic p;
    p = ~(^b) ^ bad_par;
    send_bit(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0, 1'b0, 1'b0);
    send_bit(p, 1'b0, 1'b0, 1'b0);
    send_bit(!bad_stop, 1'b1, pop, chk_lat);
    PS2_DATA = 1'b1;
    tick(HALF);
    if (bad_par || bad_stop) begin
      mdl_ext = 1'b0;
      mdl_rel = 1'b0;
    end else if (b == 8'hE0) begin
      mdl_ext = 1'b1;
    end else if (b == 8'hF0) begin
      mdl_rel = 1'b1;
    end else begin
      if (mdl_count < FD) begin
        exp_q.push_back({mdl_ext, mdl_rel, b});
        mdl_count++;
      end
      mdl_ext = 1'b0;
      mdl_rel = 1'b0;
    end
  endtask

  task automatic drain();
    int guard;
    logic [9:0] e;
    guard = 0;
    @(negedge CLK);
    while (rd_valid === 1'b1 && guard < FD + 4) begin
      guard++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("fifo_head", rd_data, e);
      end else begin
        check("unexpected_entry", rd_valid, 1'b0);
      end
      rd_en = 1'b1;
      @(posedge CLK);
      #1;
      rd_en = 1'b0;
      @(negedge CLK);
    end
    check("drain_missing", exp_q.size(), 0);
    check("drain_count", fifo_count, 0);
    exp_q.delete();
    mdl_count = 0;
  endtask

  task automatic model_clear();
    exp_q.delete();
    mdl_count = 0;
    mdl_ext   = 1'b0;
    mdl_rel   = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; PS2_CLK = 1'b1; PS2_DATA = 1'b1; rd_en = 1'b0;
    model_clear();
    tick(3);
    reset = 1'b0;
    tick(2);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_rd_data", rd_data, 10'h000);
    check("rst_overflow", overflow, 1'b0);
    check("rst_errs", {parity_err, frame_err}, 2'b00);

    // Single good frame with latency check.
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0, 1'b1);
    check("one_entry_count", fifo_count, 1);
    drain();

    // Parity error.
    p0 = perr_cnt; f0 = ferr_cnt;
    send_frame(8'h1C, 1'b1, 1'b0, 1'b0, 1'b0);
    check("perr_pulse", perr_cnt, p0 + 1);
    check("perr_no_ferr", ferr_cnt, f0);
    check("perr_no_push", fifo_count, 0);

    // Prefix folding.
    send_frame(8'hE0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
    check("prefix_count", fifo_count, 2);
    drain();

    // Bad stop bit (with bad parity too) clears a pending prefix.
    p0 = perr_cnt; f0 = ferr_cnt;
    send_frame(8'hE0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h55, 1'b1, 1'b1, 1'b0, 1'b0);
    check("stop_ferr", ferr_cnt, f0 + 1);
    check("stop_no_perr", perr_cnt, p0);
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();

    // Timeout after four bits.
    f0 = ferr_cnt;
    send_bit(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0, 1'b0, 1'b0);
    PS2_DATA = 1'b1;
    tick(TO + 40);
    check("timeout_ferr", ferr_cnt, f0 + 1);
    check("timeout_no_push", fifo_count, 0);
    send_frame(8'h29, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();

    // Fill, push-with-pop at full, then overflow.
    for (int i = 0; i < FD; i++) send_frame(8'h10 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    check("full_count", fifo_count, FD);
    check("full_no_ovf", overflow, 1'b0);
    send_frame(8'h20, 1'b0, 1'b0, 1'b1, 1'b0);
    check("pushpop_count", fifo_count, FD);
    check("pushpop_no_ovf", overflow, 1'b0);
    send_frame(8'h21, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ovf_count", fifo_count, FD);
    check("ovf_set", overflow, 1'b1);
    @(negedge CLK);
    check("ovf_head_kept", rd_data, exp_q[0]);
    drain();
    check("ovf_sticky", overflow, 1'b1);

    // Short clock glitch while idle with data low.
    f0 = ferr_cnt;
    PS2_DATA = 1'b0; PS2_CLK = 1'b0;
    tick(FL - 1);
    PS2_CLK = 1'b1; PS2_DATA = 1'b1;
    tick(TO + 40);
    check("glitch_no_ferr", ferr_cnt, f0);
    check("glitch_no_push", fifo_count, 0);
    send_frame(8'h29, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();

    // Reset mid-frame with a queued entry and sticky overflow.
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b0, 1'b0, 1'b0);
    p0 = perr_cnt; f0 = ferr_cnt;
    reset = 1'b1;
    tick(1);
    check("midrst_rd_valid", rd_valid, 1'b0);
    check("midrst_count", fifo_count, 0);
    check("midrst_rd_data", rd_data, 10'h000);
    check("midrst_flags", {parity_err, frame_err, overflow}, 3'b000);
    reset = 1'b0; PS2_DATA = 1'b1;
    model_clear();
    tick(TO + 40);
    check("midrst_no_ferr", ferr_cnt, f0);
    check("midrst_no_perr", perr_cnt, p0);
    check("midrst_no_push", fifo_count, 0);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
